// File: rtl/fetch_ifid_stage_if.sv
// Bundle between the fetch/IF-ID stage and its environment (hazard controller, instruction memory).
// STALL_WATCHDOG_EN adds the sticky StallTimeout output.
interface fetch_ifid_stage_if #(
  parameter int unsigned PC_W = 16
);
  logic            PCStall;
  logic            MP;
  logic [PC_W-1:0] BranchTarget;
  logic [15:0]     ImemData;
  logic [PC_W-1:0] ImemAddr;
  logic [15:0]     IFID;
  logic [PC_W-1:0] IFIDPC;
  logic            IFIDValid;
  logic            IDEXFlush;
  logic [1:0]      State;
  logic [7:0]      StallCount;
`ifdef STALL_WATCHDOG_EN
  logic            StallTimeout;
`endif

  // Environment side: controller and instruction memory.
  modport master (
    output PCStall, MP, BranchTarget, ImemData,
    input  ImemAddr, IFID, IFIDPC, IFIDValid, IDEXFlush, State, StallCount
`ifdef STALL_WATCHDOG_EN
    , input StallTimeout
`endif
  );

  // Fetch stage side.
  modport slave (
    input  PCStall, MP, BranchTarget, ImemData,
    output ImemAddr, IFID, IFIDPC, IFIDValid, IDEXFlush, State, StallCount
`ifdef STALL_WATCHDOG_EN
    , output StallTimeout
`endif
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with IF/ID register, stall and mispredict redirect handling.
// Optional STALL_WATCHDOG_EN: sticky StallTimeout when a saturated StallCount would increment.
module fetch_ifid_stage #(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
  input logic                  clock,
  input logic                  reset,
  fetch_ifid_stage_if.slave    bus
);

  typedef enum logic [1:0] {
    StBoot     = 2'd0,
    StRun      = 2'd1,
    StStall    = 2'd2,
    StRedirect = 2'd3
  } state_e;

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ifid;
  logic [PC_W-1:0] r_ifidpc;
  logic            r_valid;
  logic [7:0]      r_stall_cnt;
`ifdef STALL_WATCHDOG_EN
  logic            r_timeout;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= StBoot;
      r_pc        <= RESET_PC;
      r_ifid      <= NOP_INSTR;
      r_ifidpc    <= '0;
      r_valid     <= 1'b0;
      r_stall_cnt <= 8'd0;
`ifdef STALL_WATCHDOG_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StBoot: begin
          r_ifid   <= bus.ImemData;
          r_ifidpc <= r_pc;
          r_valid  <= 1'b1;
          r_pc     <= r_pc + 1'b1;
          r_state  <= StRun;
        end
        StRun, StStall, StRedirect: begin
          if (bus.MP) begin
            r_pc        <= bus.BranchTarget;
            r_ifid      <= NOP_INSTR;
            r_ifidpc    <= bus.BranchTarget;
            r_valid     <= 1'b0;
            r_stall_cnt <= 8'd0;
            r_state     <= StRedirect;
          end else if (bus.PCStall && (r_state != StRedirect)) begin
            // IF/ID holds a bubble during REDIRECT, so stalls are only honoured outside it.
            if (r_stall_cnt == 8'hFF) begin
`ifdef STALL_WATCHDOG_EN
              r_timeout <= 1'b1;
`endif
            end else begin
              r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            r_state <= StStall;
          end else begin
            r_ifid      <= bus.ImemData;
            r_ifidpc    <= r_pc;
            r_valid     <= 1'b1;
            r_pc        <= r_pc + 1'b1;
            r_stall_cnt <= 8'd0;
            r_state     <= StRun;
          end
        end
      endcase
    end
  end

  assign bus.ImemAddr   = r_pc;
  assign bus.IFID       = r_ifid;
  assign bus.IFIDPC     = r_ifidpc;
  assign bus.IFIDValid  = r_valid;
  assign bus.State      = r_state;
  assign bus.StallCount = r_stall_cnt;
  assign bus.IDEXFlush  = bus.MP && (r_state != StBoot);
`ifdef STALL_WATCHDOG_EN
  assign bus.StallTimeout = r_timeout;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Randomized self-checking bench for fetch_ifid_stage against a rule-level reference model.
// Build with STALL_WATCHDOG_EN defined to also check StallTimeout.
module tb_fetch_ifid_stage;
  localparam int unsigned PC_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_ifid_stage_if #(.PC_W(PC_W)) bus ();

  fetch_ifid_stage #(
    .PC_W     (PC_W),
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] mem [65536];
  assign bus.ImemData = mem[bus.ImemAddr];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state named by the rules it follows, not by the RTL encoding.
  logic [15:0] m_pc, m_ifid, m_ifidpc;
  bit          m_valid, m_to, m_known;
  bit          m_booting, m_redirect, m_stalled;
  int          m_cnt;

  function automatic int exp_state();
    if (m_booting)  return 0;
    if (m_redirect) return 3;
    if (m_stalled)  return 2;
    return 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit stall, input bit mp,
                            input logic [15:0] tgt);
    if (!rst_n) begin
      m_pc = 16'h0000; m_ifid = 16'h0000; m_ifidpc = 16'h0000; m_valid = 0;
      m_booting = 1; m_redirect = 0; m_stalled = 0; m_cnt = 0; m_to = 0;
      m_known = 1;
      return;
    end
    if (!m_known) return;
    if (!m_booting && mp) begin
      m_pc = tgt; m_ifid = 16'h0000; m_ifidpc = tgt; m_valid = 0; m_cnt = 0;
      m_redirect = 1; m_stalled = 0;
    end else if (!m_booting && !m_redirect && stall) begin
      if (m_cnt == 255) m_to = 1;
      else m_cnt = m_cnt + 1;
      m_stalled = 1;
    end else begin
      m_ifid = mem[m_pc]; m_ifidpc = m_pc; m_valid = 1;
      m_pc = 16'((32'(m_pc) + 1) % 65536);
      if (!m_booting) m_cnt = 0;
      m_booting = 0; m_redirect = 0; m_stalled = 0;
    end
  endtask

  task automatic check_all();
    check_eq("imem_addr", bus.ImemAddr, m_pc);
    check_eq("ifid", bus.IFID, m_ifid);
    check_eq("ifid_pc", bus.IFIDPC, m_ifidpc);
    check_eq("ifid_valid", bus.IFIDValid, m_valid);
    check_eq("state", bus.State, exp_state());
    check_eq("stall_count", bus.StallCount, m_cnt);
`ifdef STALL_WATCHDOG_EN
    check_eq("stall_timeout", bus.StallTimeout, m_to);
`endif
  endtask

  task automatic step(input bit rst_n, input bit stall, input bit mp, input logic [15:0] tgt);
    @(negedge clock);
    reset = rst_n; bus.PCStall = stall; bus.MP = mp; bus.BranchTarget = tgt;
    #1;
    if (m_known) begin
      check_eq("pre_imem_addr", bus.ImemAddr, m_pc);
      check_eq("idex_flush", bus.IDEXFlush, (!m_booting && mp));
    end
    @(posedge clock);
    model_edge(rst_n, stall, mp, tgt);
    #1;
    if (m_known) check_all();
  endtask

  task automatic advance_to(input logic [15:0] pc);
    for (int i = 0; i < 64 && m_pc != pc; i++) step(1, 0, 0, 16'h0);
    check_eq("reach_pc", bus.ImemAddr, pc);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h4A01;
    mem[1] = 16'h2C80;
    m_known = 0;
    bus.PCStall = 0; bus.MP = 0; bus.BranchTarget = '0;

    // Reset and boot sequence.
    step(0, 0, 0, 16'h0);
    step(0, 1, 1, 16'h1234);
    check_eq("rst_state", bus.State, 0);
    check_eq("rst_addr", bus.ImemAddr, 0);
    step(1, 1, 1, 16'h1234);
    check_eq("boot_ifid", bus.IFID, 16'h4A01);
    check_eq("boot_valid", bus.IFIDValid, 1);
    check_eq("boot_addr", bus.ImemAddr, 1);
    check_eq("boot_state", bus.State, 1);
    step(1, 0, 0, 16'h0);
    check_eq("second_ifid", bus.IFID, 16'h2C80);

    // Three-cycle stall at PC=5.
    advance_to(16'h0005);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 16'h0);
      check_eq("stall_addr", bus.ImemAddr, 5);
      check_eq("stall_cnt_seq", bus.StallCount, 32'(i + 1));
      check_eq("stall_state", bus.State, 2);
    end
    step(1, 0, 0, 16'h0);
    check_eq("release_cnt", bus.StallCount, 0);
    check_eq("release_ifidpc", bus.IFIDPC, 5);

    // Mispredict with simultaneous stall at PC=8.
    advance_to(16'h0008);
    step(1, 1, 1, 16'h0020);
    check_eq("redir_addr", bus.ImemAddr, 16'h0020);
    check_eq("redir_ifid", bus.IFID, 16'h0000);
    check_eq("redir_valid", bus.IFIDValid, 0);
    check_eq("redir_state", bus.State, 3);
    step(1, 1, 0, 16'h0);
    check_eq("target_ifid", bus.IFID, mem[16'h0020]);
    check_eq("target_pc", bus.IFIDPC, 16'h0020);
    check_eq("target_state", bus.State, 1);

    // PC wrap.
    step(1, 0, 1, 16'hFFFF);
    step(1, 0, 0, 16'h0);
    check_eq("wrap_addr", bus.ImemAddr, 16'h0000);
    check_eq("wrap_ifidpc", bus.IFIDPC, 16'hFFFF);

    // Saturation over a long stall.
    for (int i = 1; i <= 300; i++) begin
      step(1, 1, 0, 16'h0);
`ifdef STALL_WATCHDOG_EN
      if (i == 255 || i == 256) check_eq("wd_edge", bus.StallTimeout, (i >= 256));
`endif
    end
    check_eq("sat_cnt", bus.StallCount, 255);
    step(1, 0, 0, 16'h0);
`ifdef STALL_WATCHDOG_EN
    check_eq("wd_sticky", bus.StallTimeout, 1);
`endif

    // Reset mid-stall.
    for (int i = 0; i < 40; i++) step(1, 1, 0, 16'h0);
    check_eq("cnt_40", bus.StallCount, 40);
    step(0, 1, 1, 16'h0055);
    check_eq("mid_rst_state", bus.State, 0);
    check_eq("mid_rst_cnt", bus.StallCount, 0);
    check_eq("mid_rst_addr", bus.ImemAddr, 0);
    check_eq("mid_rst_valid", bus.IFIDValid, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) >= 2), ($urandom_range(99) < 30), ($urandom_range(99) < 10),
           16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
